// File: rtl/fir_filter_param.sv
// Parameterised direct-form FIR filter with one shared multiplier, time-multiplexed over taps.
// Latency: sample accepted at edge T -> out_valid from edge T+TAPS+1; next accept no earlier than T+TAPS+3.
// Backpressure: result held in OUT until out_ready; in_ready is low outside IDLE.
// Optional build macro FIR_FILTER_SAT_EN: saturate out_data on overflow instead of two's-complement wrap.
module fir_filter_param #(
    parameter  int DATA_W = 16,
    parameter  int COEF_W = 16,
    parameter  int TAPS   = 8,
    parameter  int OUT_W  = 24,
    localparam int AW     = $clog2(TAPS),
    localparam int ACC_W  = DATA_W + COEF_W + AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_ovf,
    output logic                     busy
);

    localparam int PROD_W = DATA_W + COEF_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                     state;
    logic [AW-1:0]              k;
    logic signed [DATA_W-1:0]   x_line [TAPS];
    logic signed [COEF_W-1:0]   h      [TAPS];
    logic signed [ACC_W-1:0]    acc;

    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [ACC_W-OUT_W:0]       acc_top;
    logic                       acc_ovf;
    logic [OUT_W-1:0]           out_next;
    logic                       accept;
    logic                       coef_ok;

    // Handshake qualifiers: a sample is only taken in IDLE, coefficient writes
    // are dropped while the MAC pass is reading the coefficient bank.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_ready && in_valid;
    assign coef_ok  = coef_we && (state != MAC) &&
                      ({1'b0, coef_addr} < (AW + 1)'(TAPS));

    // The one shared multiplier, sign-extended to accumulator width.
    assign prod     = x_line[k] * h[k];
    assign prod_ext = {{AW{prod[PROD_W-1]}}, prod};

    // The result fits OUT_W only if all bits from the OUT_W sign bit upwards agree.
    assign acc_top  = acc[ACC_W-1:OUT_W-1];
    assign acc_ovf  = !((&acc_top) || !(|acc_top));

    // Output formatting: clamp to the signed rails or keep the low bits.
    always_comb begin
        out_next = acc[OUT_W-1:0];
`ifdef FIR_FILTER_SAT_EN
        if (acc_ovf) begin
            if (acc[ACC_W-1]) begin
                out_next = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                out_next = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
`endif
    end

    // Delay line: shifts only on an accepted sample, newest sample in slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x_line[i] <= '0;
            end
        end else if (accept) begin
            x_line[0] <= in_data;
            for (int i = 1; i < TAPS; i++) begin
                x_line[i] <= x_line[i-1];
            end
        end
    end

    // Coefficient bank: a write landing with a sample accept is seen by that sample's MAC pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                h[i] <= '0;
            end
        end else if (coef_ok) begin
            h[coef_addr] <= coef_data;
        end
    end

    // Control FSM with accumulator and registered result. The first OUT cycle
    // registers the formatted result, so out_valid rises one edge after the last MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (k == AW'(TAPS - 1)) begin
                        k     <= '0;
                        state <= OUT;
                    end else begin
                        k <= k + AW'(1);
                    end
                end
                OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= out_next;
                        out_ovf   <= acc_ovf;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// Scoreboard bench for fir_filter_param: randomized and directed samples against a sum-of-products model.
// Latency and data are checked by an independent monitor on every output handshake.
// Backpressure is exercised by stalling and randomizing out_ready.
module tb_fir_filter_param;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 8;
    localparam int OUT_W  = 24;
    localparam int AW     = $clog2(TAPS);

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic                     out_ovf;
    logic                     busy;

    fir_filter_param #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .busy(busy)
    );

    typedef struct {
        longint acc;
        int     acc_cyc;
    } exp_t;

    exp_t   sb [$];
    longint h_m  [TAPS];
    longint x_m  [TAPS];
    int     n_chk;
    int     n_fail;
    int     cyc;
    bit     rand_mode;
    logic   prev_valid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    // Expected result formatting derived directly from the accumulator value.
    function automatic logic [OUT_W-1:0] exp_data(input longint a);
        longint omax;
        longint omin;
        logic [OUT_W-1:0] r;
        omax = (longint'(1) <<< (OUT_W - 1)) - 1;
        omin = -(longint'(1) <<< (OUT_W - 1));
        r = a[OUT_W-1:0];
`ifdef FIR_FILTER_SAT_EN
        if (a > omax) r = omax[OUT_W-1:0];
        if (a < omin) r = omin[OUT_W-1:0];
`endif
        return r;
    endfunction

    function automatic logic exp_ovf(input longint a);
        longint omax;
        longint omin;
        omax = (longint'(1) <<< (OUT_W - 1)) - 1;
        omin = -(longint'(1) <<< (OUT_W - 1));
        return (a > omax) || (a < omin);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) begin
            h_m[i] = 0;
            x_m[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) chk(nm, 64'(in_ready), 64'd1);
    endtask

    task automatic write_coef(input int a, input logic signed [COEF_W-1:0] d);
        wait_ready("coef_wait_idle");
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = d;
        if (a < TAPS) h_m[a] = longint'(d);
        tick();
        coef_we = 1'b0;
    endtask

    // Accept one sample (optionally with a coincident coefficient write) and queue its expected result.
    task automatic send(input logic signed [DATA_W-1:0] d, input bit wr,
                        input int a, input logic signed [COEF_W-1:0] cd);
        exp_t   e;
        longint s;
        wait_ready("in_ready_wait");
        in_valid = 1'b1;
        in_data  = d;
        if (wr) begin
            coef_we   = 1'b1;
            coef_addr = AW'(a);
            coef_data = cd;
            if (a < TAPS) h_m[a] = longint'(cd);
        end
        for (int i = TAPS - 1; i > 0; i--) x_m[i] = x_m[i-1];
        x_m[0] = longint'(d);
        s = 0;
        for (int i = 0; i < TAPS; i++) s += h_m[i] * x_m[i];
        tick();
        e.acc     = s;
        e.acc_cyc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        if (sb.size() != 0) chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: latency on each out_valid rise, data/ovf on each handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(TAPS + 1));
                end
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                chk("out_data", 64'(out_data), 64'(exp_data(sb[0].acc)));
                chk("out_ovf", 64'(out_ovf), 64'(exp_ovf(sb[0].acc)));
                void'(sb.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        logic [OUT_W-1:0] held;
        int n;
        int seen;
        n_chk = 0; n_fail = 0; cyc = 0; rand_mode = 1'b0; prev_valid = 1'b0;
        rst_n = 1'b1; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b1;
        model_clear();

        // Reset state
        #3 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Impulse response: h = 1..8
        for (int i = 0; i < TAPS; i++) write_coef(i, COEF_W'(i + 1));
        send(16'sd1, 1'b0, 0, '0);
        for (int i = 1; i < TAPS; i++) send(16'sd0, 1'b0, 0, '0);
        drain();

        // Backpressure: hold the result for 5 cycles; in_valid during OUT is ignored
        out_ready = 1'b0;
        send(16'sd1234, 1'b0, 0, '0);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        held     = out_data;
        in_valid = 1'b1;
        in_data  = 16'sd77;
        repeat (5) begin
            tick();
            chk("bp_data_stable", 64'(out_data), 64'(held));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_rel_in_ready", 64'(in_ready), 64'd1);
        chk("bp_rel_busy", 64'(busy), 64'd0);
        chk("bp_rel_valid", 64'(out_valid), 64'd0);

        // Overflow: all taps and samples at full positive scale
        for (int i = 0; i < TAPS; i++) write_coef(i, 16'sd32767);
        for (int i = 0; i < TAPS; i++) send(16'sd32767, 1'b0, 0, '0);
        drain();
        chk("ovf_model_acc", 64'(sb.size()), 64'd0);

        // Coefficient write during MAC is dropped; in IDLE it applies to the same accept
        for (int i = 0; i < TAPS; i++) write_coef(i, COEF_W'(i + 1));
        send(16'sd5, 1'b0, 0, '0);
        tick(); tick();
        coef_we = 1'b1; coef_addr = '0; coef_data = 16'sd100;
        tick();
        coef_we = 1'b0;
        send(16'sd7, 1'b0, 0, '0);
        send(16'sd9, 1'b1, 0, 16'sd100);
        send(-16'sd3, 1'b0, 0, '0);
        drain();

        // Reset mid-MAC at k=3: everything clears at once, nothing emerges afterwards
        send(16'sd3, 1'b0, 0, '0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("amid_busy", 64'(busy), 64'd0);
        chk("amid_in_ready", 64'(in_ready), 64'd1);
        chk("amid_out_valid", 64'(out_valid), 64'd0);
        chk("amid_out_data", 64'(out_data), 64'd0);
        sb.delete();
        model_clear();
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            tick();
            if (out_valid) seen++;
        end
        chk("amid_no_output", 64'(seen), 64'd0);
        send(DATA_W'($urandom), 1'b0, 0, '0);
        drain();

        // Randomized traffic with random coefficients and random out_ready
        for (int i = 0; i < TAPS; i++) write_coef(i, COEF_W'($urandom));
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                write_coef(int'($urandom_range(0, TAPS - 1)), COEF_W'($urandom));
            end
            if ($urandom_range(0, 3) == 0) begin
                send(DATA_W'($urandom), 1'b1, int'($urandom_range(0, TAPS - 1)), COEF_W'($urandom));
            end else begin
                send(DATA_W'($urandom), 1'b0, 0, '0);
            end
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
